branch_predictor: RTL and testbench

//  Fetch-side branch prediction unit and PC owner for the 5-stage pipeline; the initiator paired with

---
 rtl/bpu_pkg.sv | 13 +
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bpu_pkg.sv
// Shared widths and 2-bit counter encodings for the fetch-side branch predictor.
package bpu_pkg;
    localparam int PC_W   = 10;
    localparam int IDX_W  = 4;
    localparam int MISS_W = 16;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/decode signal bundle between the predictor (master) and the pipeline (slave).
interface branch_predictor_if
    import bpu_pkg::*;
#(
    parameter int P_PC_W   = PC_W,
    parameter int P_MISS_W = MISS_W
) ();
    logic                hold;
    logic                branch_D;
    logic                pcsrc_D;
    logic                predTaken_D;
    logic [P_PC_W-1:0]   pc_D;
    logic [P_PC_W-1:0]   target_D;
    logic                jump_D;
    logic [P_PC_W-1:0]   jaddress_D;
    logic [P_PC_W-1:0]   pc_F;
    logic                predTaken_F;
    logic                flush_IF;
    logic                mispredict;
    logic [P_MISS_W-1:0] missCount;

    modport master (
        input  hold, branch_D, pcsrc_D, predTaken_D, pc_D, target_D, jump_D, jaddress_D,
        output pc_F, predTaken_F, flush_IF, mispredict, missCount
    );

    modport slave (
        output hold, branch_D, pcsrc_D, predTaken_D, pc_D, target_D, jump_D, jaddress_D,
        input  pc_F, predTaken_F, flush_IF, mispredict, missCount
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating direction counter.
module sat_counter2
    import bpu_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_next_o
);
    // Step one state toward the observed direction, clamping at SNT/ST.
    always_comb begin
        ctr_next_o = ctr_i;
        case (ctr_i)
            SNT:     ctr_next_o = taken_i ? WNT : SNT;
            WNT:     ctr_next_o = taken_i ? WT  : SNT;
            WT:      ctr_next_o = taken_i ? ST  : WNT;
            ST:      ctr_next_o = taken_i ? ST  : WT;
            default: ctr_next_o = WNT;
        endcase
    end
endmodule

// File: rtl/branch_predictor.sv
// PC owner with direct-mapped BTB and 2-bit counters; redirects fetch on decode
// mispredicts and jumps, squashing the wrong-path instruction in IF/ID.
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int P_PC_W   = PC_W,
    parameter int P_IDX_W  = IDX_W,
    parameter int P_MISS_W = MISS_W
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.master bp
);
    localparam int ENTRIES = 1 << P_IDX_W;
    localparam int TAG_W   = P_PC_W - P_IDX_W;

    logic [P_PC_W-1:0]   pc_q, pc_d;
    logic [P_MISS_W-1:0] miss_q, miss_d;
    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [P_PC_W-1:0]   target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [P_IDX_W-1:0]  lk_idx_s, up_idx_s;
    logic                lk_hit_s, up_hit_s, pred_s;
    logic                resolve_s, misp_s, jump_s;
    logic [P_PC_W-1:0]   correct_pc_s;
    logic [1:0]          ctr_nx_s;

    assign lk_idx_s     = pc_q[P_IDX_W-1:0];
    assign lk_hit_s     = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == pc_q[P_PC_W-1:P_IDX_W]);
    assign pred_s       = lk_hit_s & ctr_q[lk_idx_s][1];

    assign resolve_s    = bp.branch_D & ~bp.hold;
    assign misp_s       = resolve_s & (bp.pcsrc_D != bp.predTaken_D);
    assign jump_s       = bp.jump_D & ~bp.hold;
    assign correct_pc_s = bp.pcsrc_D ? bp.target_D : bp.pc_D + P_PC_W'(1);

    assign up_idx_s     = bp.pc_D[P_IDX_W-1:0];
    assign up_hit_s     = valid_q[up_idx_s] && (tag_q[up_idx_s] == bp.pc_D[P_PC_W-1:P_IDX_W]);

    sat_counter2 u_ctr (
        .ctr_i      (ctr_q[up_idx_s]),
        .taken_i    (bp.pcsrc_D),
        .ctr_next_o (ctr_nx_s)
    );

    // Next fetch PC: mispredict recovery beats jump, jump beats stall, stall beats prediction.
    always_comb begin
        pc_d = pc_q + P_PC_W'(1);
        if (misp_s) begin
            pc_d = correct_pc_s;
        end else if (jump_s) begin
            pc_d = bp.jaddress_D;
        end else if (bp.hold) begin
            pc_d = pc_q;
        end else if (pred_s) begin
            pc_d = target_q[lk_idx_s];
        end else begin
            pc_d = pc_q + P_PC_W'(1);
        end
    end

    // Mispredict statistics saturate instead of wrapping.
    always_comb begin
        if (misp_s && (miss_q != {P_MISS_W{1'b1}})) begin
            miss_d = miss_q + P_MISS_W'(1);
        end else begin
            miss_d = miss_q;
        end
    end

    // PC, statistics and BTB state; reset suppresses any table write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= '0;
            miss_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else begin
            pc_q   <= pc_d;
            miss_q <= miss_d;
            if (resolve_s) begin
                if (up_hit_s) begin
                    ctr_q[up_idx_s] <= ctr_nx_s;
                end else if (bp.pcsrc_D) begin
                    valid_q[up_idx_s]  <= 1'b1;
                    tag_q[up_idx_s]    <= bp.pc_D[P_PC_W-1:P_IDX_W];
                    target_q[up_idx_s] <= bp.target_D;
                    ctr_q[up_idx_s]    <= WT;
                end
            end
        end
    end

    assign bp.pc_F        = pc_q;
    assign bp.predTaken_F = pred_s;
    assign bp.flush_IF    = misp_s | jump_s;
    assign bp.mispredict  = misp_s;
    assign bp.missCount   = miss_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor pops and compares.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if bif ();

    branch_predictor dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif)
    );

    typedef struct {
        bit chk;
        int cyc;
        int pc;
        bit pt;
        bit flush;
        bit misp;
        int miss;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Reference model: plain integers, one record per BTB slot.
    int m_pc = 0;
    int m_miss = 0;
    bit m_valid [16];
    int m_tag   [16];
    int m_tgt   [16];
    int m_ctr   [16];

    task automatic step(input bit r, input bit h, input bit br, input bit taken, input bit ptd,
                        input int pcd, input int tgt, input bit j, input int ja, input bit chk);
        exp_t e;
        int   li, ui, npc;
        bit   hit, pt, res, misp;
        @(posedge clk);
        #1;
        rst            = r;
        bif.hold        = h;
        bif.branch_D    = br;
        bif.pcsrc_D     = taken;
        bif.predTaken_D = ptd;
        bif.pc_D        = 10'(pcd);
        bif.target_D    = 10'(tgt);
        bif.jump_D      = j;
        bif.jaddress_D  = 10'(ja);
        cyc++;

        li   = m_pc % 16;
        pt   = m_valid[li] && (m_tag[li] == m_pc / 16) && (m_ctr[li] >= 2);
        res  = br && !h;
        misp = res && (taken != ptd);

        e.chk   = chk;
        e.cyc   = cyc;
        e.pc    = m_pc;
        e.pt    = pt;
        e.flush = misp || (j && !h);
        e.misp  = misp;
        e.miss  = m_miss;
        sb.push_back(e);

        if (!r) begin
            m_pc   = 0;
            m_miss = 0;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
        end else begin
            if (misp)             npc = taken ? tgt : (pcd + 1) % 1024;
            else if (j && !h)     npc = ja;
            else if (h)           npc = m_pc;
            else if (pt)          npc = m_tgt[li];
            else                  npc = (m_pc + 1) % 1024;
            if (misp && m_miss < 65535) m_miss++;
            if (res) begin
                ui  = pcd % 16;
                hit = m_valid[ui] && (m_tag[ui] == pcd / 16);
                if (hit) begin
                    m_ctr[ui] = taken ? ((m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1)
                                      : ((m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1);
                end else if (taken) begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = pcd / 16;
                    m_tgt[ui]   = tgt;
                    m_ctr[ui]   = 2;
                end
            end
            m_pc = npc;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: outputs are valid every cycle, so each negedge retires one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    n_checks += 5;
                    if (int'(bif.pc_F) != e.pc) begin
                        n_errors++;
                        $display("FAIL pc_F cyc %0d: got %0d expected %0d", e.cyc, bif.pc_F, e.pc);
                    end
                    if (bif.predTaken_F !== e.pt) begin
                        n_errors++;
                        $display("FAIL predTaken_F cyc %0d: got %b expected %b", e.cyc, bif.predTaken_F, e.pt);
                    end
                    if (bif.flush_IF !== e.flush) begin
                        n_errors++;
                        $display("FAIL flush_IF cyc %0d: got %b expected %b", e.cyc, bif.flush_IF, e.flush);
                    end
                    if (bif.mispredict !== e.misp) begin
                        n_errors++;
                        $display("FAIL mispredict cyc %0d: got %b expected %b", e.cyc, bif.mispredict, e.misp);
                    end
                    if (int'(bif.missCount) != e.miss) begin
                        n_errors++;
                        $display("FAIL missCount cyc %0d: got %0d expected %0d", e.cyc, bif.missCount, e.miss);
                    end
                end
            end
        end
    end

    initial begin
        int  wait_cyc;
        bit  h, br, tk, ptd, j, r;
        rst = 1'b0;
        bif.hold = 1'b0; bif.branch_D = 1'b0; bif.pcsrc_D = 1'b0; bif.predTaken_D = 1'b0;
        bif.pc_D = '0; bif.target_D = '0; bif.jump_D = 1'b0; bif.jaddress_D = '0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(6);
        // Cold taken branch at 5 -> 20: mispredict, allocate WT.
        step(1, 0, 1, 1, 0, 5, 20, 0, 0, 1);
        idle(2);
        // Revisit 5: predicted taken to 20; confirm taken -> ST.
        step(1, 0, 0, 0, 0, 0, 0, 1, 5, 1);
        idle(2);
        step(1, 0, 1, 1, 1, 5, 20, 0, 0, 1);
        // Not taken twice: ST->WT (flush to 6), WT->WNT.
        step(1, 0, 1, 0, 1, 5, 20, 0, 0, 1);
        step(1, 0, 1, 0, 0, 5, 20, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 5, 1);
        idle(2);
        // Alias 21 shares index 5: retrain then replace, then lookup at 5 misses.
        step(1, 0, 1, 1, 1, 5, 20, 0, 0, 1);
        step(1, 0, 1, 1, 0, 21, 30, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 5, 1);
        idle(2);
        // Hold masks resolution; jump redirects without touching missCount.
        step(1, 1, 1, 1, 0, 7, 40, 0, 0, 1);
        step(1, 1, 1, 1, 0, 7, 40, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 33, 1);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 7, 1);
        idle(1);
        // Wrap-around at the top of the address space.
        step(1, 0, 0, 0, 0, 0, 0, 1, 1021, 1);
        idle(5);
        // Reset during a redirect: reset wins, no allocation at 9.
        step(0, 0, 1, 1, 0, 9, 44, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 9, 1);
        idle(2);

        for (int k = 0; k < 600; k++) begin
            r   = ($urandom_range(0, 99) >= 2);
            h   = ($urandom_range(0, 99) < 20);
            br  = ($urandom_range(0, 99) < 40);
            j   = !br && ($urandom_range(0, 99) < 12);
            tk  = $urandom_range(0, 1);
            ptd = $urandom_range(0, 1);
            step(r, h, br, tk, ptd, $urandom_range(0, 47), $urandom_range(0, 47),
                 j, $urandom_range(0, 47), 1);
        end
        idle(1);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
